// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side controller for a 32x32 register file.
// Merges single-cycle ALU results and queued multi-cycle results onto the
// one registered write port, and tracks outstanding multi-cycle destinations
// in a per-register pending scoreboard.
// Optional macro REGFILE_WB_FWD_EN adds combinational forwarding of the
// write currently presented on we/rd/wd to the two checked source indices.
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [AW-1:0]   mc_rd,
  input  logic [XLEN-1:0] mc_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            we,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] wd
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic            fwd_rs1_hit,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_rs2_data
`endif
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  // Multi-cycle result queue storage and bookkeeping
  logic [AW-1:0]   q_rd   [LQ_DEPTH];
  logic [XLEN-1:0] q_data [LQ_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;

  // Arbitration state
  logic [SW-1:0]   starve;
  logic            stall;
  logic            alu_win;

  // Pending scoreboard
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign mc_ready  = !full;
  assign push      = mc_valid && !full;
  assign head_rd   = q_rd[rd_ptr];
  assign head_data = q_data[rd_ptr];

  // Queue wins only after it has lost STARVE_MAX cycles in a row; the ALU
  // otherwise has priority, and a refused ALU result must be held upstream.
  assign stall     = (starve == STARVE_LIM) && !empty;
  assign alu_stall = stall && alu_valid;
  assign alu_win   = alu_valid && !stall;
  assign pop       = !alu_win && !empty;

  // Queue entry storage: written on push, no reset needed for data
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= mc_rd;
      q_data[wr_ptr] <= mc_data;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at LQ_DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: counts ALU wins over a waiting queue, saturating
  always_ff @(posedge clk) begin
    if (rst || empty || pop) begin
      starve <= '0;
    end else if (alu_win && (starve != STARVE_LIM)) begin
      starve <= starve + SW'(1);
    end
  end

  // Registered write port: ALU first, then queue head, else idle with hold
  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      rd <= '0;
      wd <= '0;
    end else if (alu_win) begin
      we <= (alu_rd != '0);
      rd <= alu_rd;
      wd <= alu_data;
    end else if (pop) begin
      we <= (head_rd != '0);
      rd <= head_rd;
      wd <= head_data;
    end else begin
      we <= 1'b0;
    end
  end

  // Scoreboard next state: issue sets win over pop clears, x0 never set
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_rd != '0)) begin
      set_mask = NREG'(1) << issue_rd;
    end
    if (pop && (head_rd != '0)) begin
      clr_mask = NREG'(1) << head_rd;
    end
    sb_next    = (sb & ~clr_mask) | set_mask;
    sb_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  assign busy_rs1 = (chk_rs1 != '0) && sb[chk_rs1];
  assign busy_rs2 = (chk_rs2 != '0) && sb[chk_rs2];

`ifdef REGFILE_WB_FWD_EN
  // Forward the write presented this cycle, before the file commits it
  assign fwd_rs1_hit  = we && (rd != '0) && (rd == chk_rs1);
  assign fwd_rs1_data = wd;
  assign fwd_rs2_hit  = we && (rd != '0) && (rd == chk_rs2);
  assign fwd_rs2_data = wd;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: directed stimulus, expected writes queued
// in order and checked by a monitor whenever the DUT asserts we.
module tb_regfile_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
`ifdef REGFILE_WB_FWD_EN
  logic        fwd_rs1_hit;
  logic [31:0] fwd_rs1_data;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs2_data;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  vectors;
  int  miscompares;

  regfile_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_rd       (mc_rd),
    .mc_data     (mc_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2),
    .we          (we),
    .rd          (rd),
    .wd          (wd)
`ifdef REGFILE_WB_FWD_EN
    ,
    .fwd_rs1_hit (fwd_rs1_hit),
    .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_hit (fwd_rs2_hit),
    .fwd_rs2_data(fwd_rs2_data)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic iv, input logic [4:0] ird);
    alu_valid   = av;
    alu_rd      = ard;
    alu_data    = ad;
    mc_valid    = mv;
    mc_rd       = mrd;
    mc_data     = md;
    issue_valid = iv;
    issue_rd    = ird;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.rd = r;
    e.wd = d;
    exp_q.push_back(e);
  endtask

  // Stimulus plus forked write monitor (same process owns the counters)
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    chk_rs1     = 5'd0;
    chk_rs2     = 5'd0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    fork
      forever begin
        @(negedge clk);
        if (we === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_write: got rd=%0d wd=0x%0h, expected no write", rd, wd);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (rd !== e.rd || wd !== e.wd) begin
              miscompares++;
              $display("[TB] FAIL write_port: got rd=%0d wd=0x%0h, expected rd=%0d wd=0x%0h",
                       rd, wd, e.rd, e.wd);
            end
          end
        end
      end
    join_none

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_rd", 32'(rd), 32'd0);
    checkOutput("reset_wd", wd, 32'd0);
    checkOutput("reset_mc_ready", 32'(mc_ready), 32'd1);
    checkOutput("reset_busy_rs1", 32'(busy_rs1), 32'd0);
    checkOutput("reset_busy_rs2", 32'(busy_rs2), 32'd0);
    checkOutput("reset_alu_stall", 32'(alu_stall), 32'd0);

    // ALU write to x5, then ALU write to x0 (no write)
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    expectWrite(5'd5, 32'hDEADBEEF);
    tick();
    applyStimulus(1, 5'd0, 32'h0000_1111, 0, 0, 0, 0, 0);
    tick();
    checkOutput("alu_x0_we", 32'(we), 32'd0);

    // Forwarding window on a presented write to x3
    applyStimulus(1, 5'd3, 32'h55, 0, 0, 0, 0, 0);
    expectWrite(5'd3, 32'h55);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef REGFILE_WB_FWD_EN
    chk_rs2 = 5'd3;
    #1;
    checkOutput("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'd1);
    checkOutput("fwd_rs2_data", fwd_rs2_data, 32'h55);
    chk_rs2 = 5'd0;
    #1;
    checkOutput("fwd_rs2_hit_x0", 32'(fwd_rs2_hit), 32'd0);
`endif
    tick();

    // Scoreboard set by issue, cleared by queue pop of x7
    chk_rs1 = 5'd7;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h12, 0, 0);
    checkOutput("busy_rs1_x7_set", 32'(busy_rs1), 32'd1);
    checkOutput("mc_ready_empty", 32'(mc_ready), 32'd1);
    expectWrite(5'd7, 32'h12);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy_rs1_x7_pending", 32'(busy_rs1), 32'd1);
    tick();
    checkOutput("busy_rs1_x7_cleared", 32'(busy_rs1), 32'd0);
    checkOutput("pop_we_x7", 32'(we), 32'd1);

    // Set/clear collision on x9: set wins
    chk_rs2 = 5'd9;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
    expectWrite(5'd9, 32'h99);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy_rs2_x9_collision", 32'(busy_rs2), 32'd1);
    tick();

    // Fill the queue under constant ALU traffic; starvation forces a pop
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 5'd10, 32'hA0 + 32'(i), 1, 5'(20 + i), 32'hE0 + 32'(i), 0, 0);
      checkOutput("fill_alu_stall", 32'(alu_stall), 32'd0);
      checkOutput("fill_mc_ready", 32'(mc_ready), 32'd1);
      expectWrite(5'd10, 32'hA0 + 32'(i));
      tick();
    end
    applyStimulus(1, 5'd10, 32'hA4, 1, 5'd31, 32'hFF, 0, 0);
    checkOutput("full_mc_ready", 32'(mc_ready), 32'd0);
    checkOutput("starved_alu_stall", 32'(alu_stall), 32'd1);
    expectWrite(5'd20, 32'hE0);
    tick();
    applyStimulus(1, 5'd10, 32'hA4, 0, 0, 0, 0, 0);
    checkOutput("resume_alu_stall", 32'(alu_stall), 32'd0);
    checkOutput("resume_mc_ready", 32'(mc_ready), 32'd1);
    expectWrite(5'd10, 32'hA4);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(5'd21, 32'hE1);
    expectWrite(5'd22, 32'hE2);
    expectWrite(5'd23, 32'hE3);
    tick();
    tick();
    tick();
    tick();
    tick();

    // Reset mid-operation discards the queue, scoreboard and in-flight write
    chk_rs1 = 5'd12;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd12);
    tick();
    checkOutput("busy_rs1_x12_set", 32'(busy_rs1), 32'd1);
    applyStimulus(1, 5'd11, 32'h0B, 1, 5'd12, 32'h77, 0, 0);
    expectWrite(5'd11, 32'h0B);
    tick();
    applyStimulus(1, 5'd11, 32'h0C, 0, 0, 0, 0, 0);
    expectWrite(5'd11, 32'h0C);
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midreset_we", 32'(we), 32'd0);
    checkOutput("midreset_mc_ready", 32'(mc_ready), 32'd1);
    checkOutput("midreset_busy_rs1", 32'(busy_rs1), 32'd0);
    tick();
    tick();
    tick();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL missing_writes: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
